// File: rtl/fixed_point_mul_stage.sv
// rtl/fixed_point_mul_stage.sv - sequential element-wise fixed-point multiplier feeding the neuron accumulator
//
// Ports:
//   CLK          clock, rising edge
//   RSTN         asynchronous active-low reset
//   VALUES_IN    packed activations, element i at [i*WIDTH +: WIDTH]
//   WEIGHTS_IN   packed weights, same packing
//   VALID_IN     start request, sampled only while idle
//   BUSY_OUT     batch in flight
//   PRODUCTS_OUT packed saturated products, same packing
//   VALID_OUT    one-cycle pulse when PRODUCTS_OUT holds a new batch
//   SAT_OUT      some element of the last batch saturated
module fixed_point_mul_stage #(
  parameter int WIDTH      = 8,
  parameter int FRAC_BITS  = 3,
  parameter int NUM_INPUTS = 16
) (
  input  logic                          CLK,
  input  logic                          RSTN,
  input  logic [NUM_INPUTS*WIDTH-1:0]   VALUES_IN,
  input  logic [NUM_INPUTS*WIDTH-1:0]   WEIGHTS_IN,
  input  logic                          VALID_IN,
  output logic                          BUSY_OUT,
  output logic [NUM_INPUTS*WIDTH-1:0]   PRODUCTS_OUT,
  output logic                          VALID_OUT,
  output logic                          SAT_OUT
);

  localparam int CW = $clog2(NUM_INPUTS);
  localparam int PW = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(NUM_INPUTS - 1);
  // Saturation bounds expressed at full product width.
  localparam logic signed [PW-1:0] MAXV = {{(WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic signed [PW-1:0] MINV = {{(WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_MULTIPLY,
    S_DONE
  } state_t;

  state_t                        state_q, state_d;
  logic [CW-1:0]                 cnt_q;
  logic [NUM_INPUTS*WIDTH-1:0]   vals_q;
  logic [NUM_INPUTS*WIDTH-1:0]   wts_q;
  logic [NUM_INPUTS*WIDTH-1:0]   work_q;
  logic                          work_sat_q;
  logic [NUM_INPUTS*WIDTH-1:0]   prod_q;
  logic                          sat_q;
  logic                          valid_q;

  // Shared multiplier operating on the element selected by the counter.
  logic signed [WIDTH-1:0] op_a;
  logic signed [WIDTH-1:0] op_b;
  logic signed [PW-1:0]    full;
  logic signed [PW-1:0]    shifted;
  logic                    sat_hi;
  logic                    sat_lo;
  logic [WIDTH-1:0]        elem;

  always_comb begin
    op_a    = vals_q[cnt_q*WIDTH +: WIDTH];
    op_b    = wts_q[cnt_q*WIDTH +: WIDTH];
    full    = op_a * op_b;
    // Arithmetic shift floors toward minus infinity; no rounding term.
    shifted = full >>> FRAC_BITS;
    sat_hi  = shifted > MAXV;
    sat_lo  = shifted < MINV;
    if (sat_hi) begin
      elem = MAXV[WIDTH-1:0];
    end else if (sat_lo) begin
      elem = MINV[WIDTH-1:0];
    end else begin
      elem = shifted[WIDTH-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (VALID_IN) state_d = S_MULTIPLY;
      S_MULTIPLY: if (cnt_q == LAST) state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cnt_q      <= '0;
      vals_q     <= '0;
      wts_q      <= '0;
      work_q     <= '0;
      work_sat_q <= 1'b0;
      prod_q     <= '0;
      sat_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (VALID_IN) begin
            vals_q     <= VALUES_IN;
            wts_q      <= WEIGHTS_IN;
            cnt_q      <= '0;
            work_sat_q <= 1'b0;
          end
        end
        S_MULTIPLY: begin
          work_q[cnt_q*WIDTH +: WIDTH] <= elem;
          work_sat_q                   <= work_sat_q | sat_hi | sat_lo;
          cnt_q                        <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
        S_DONE: begin
          // Whole-vector copy so the accumulator never sees a partial batch.
          prod_q  <= work_q;
          sat_q   <= work_sat_q;
          valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign BUSY_OUT     = (state_q != S_IDLE);
  assign PRODUCTS_OUT = prod_q;
  assign VALID_OUT    = valid_q;
  assign SAT_OUT      = sat_q;

endmodule

// File: doc/fixed_point_mul_stage.md
Name: fixed_point_mul_stage

Overview:
- Element-wise fixed-point multiplier that sits directly upstream of the neuron accumulator.
- Takes a vector of NUM_INPUTS activations and a matching vector of weights.
- Computes each product with one shared signed multiplier, one element per cycle.
- Presents the full product vector in the accumulator's packed VALUES_IN format, with a one-cycle valid pulse.

Parameters:
- WIDTH, 8, bit width of every operand and product (signed, two's complement).
- FRAC_BITS, 3, fractional bits of operands and products; must be strictly positive.
- NUM_INPUTS, 16, number of elements per vector; must be at least 2.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RSTN  input  1  reset, asynchronous and active-low.
- VALUES_IN  input  NUM_INPUTS*WIDTH  packed activations; element i at [i*WIDTH +: WIDTH].
- WEIGHTS_IN  input  NUM_INPUTS*WIDTH  packed weights, same packing.
- VALID_IN  input  1  start request; sampled only in IDLE.
- BUSY_OUT  output  1  high while a batch is in flight (MULTIPLY or DONE).
- PRODUCTS_OUT  output  NUM_INPUTS*WIDTH  packed products, same packing; connects to the accumulator VALUES_IN.
- VALID_OUT  output  1  one-cycle pulse: PRODUCTS_OUT holds a new batch.
- SAT_OUT  output  1  high with/after VALID_OUT if any element of the batch saturated.

Behaviour:
- Reset (RSTN low, asynchronous):
  - State IDLE, element counter 0.
  - BUSY_OUT=0, VALID_OUT=0, SAT_OUT=0.
  - PRODUCTS_OUT=0, internal operand and working registers=0.
  - Release is synchronous to CLK.
- States: IDLE, MULTIPLY, DONE.
- IDLE:
  - VALID_IN high at edge k: latch VALUES_IN and WEIGHTS_IN into internal registers.
  - At the same edge: counter<=0, clear working saturation flag, go to MULTIPLY.
  - Inputs may change freely after edge k.
- MULTIPLY: at each edge, for element i=counter:
  - Form the 2*WIDTH-bit signed product of latched value i and weight i.
  - Arithmetic-shift it right by FRAC_BITS; this truncates toward minus infinity, with no rounding.
  - Saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Write the result into working slot i.
  - OR the saturation event into the working flag, then counter++.
  - When counter==NUM_INPUTS-1 at the edge, go to DONE.
  - Edges k+1..k+NUM_INPUTS therefore compute elements 0..NUM_INPUTS-1.
- DONE (edge k+NUM_INPUTS+1):
  - Copy the whole working vector to PRODUCTS_OUT and the working flag to SAT_OUT.
  - VALID_OUT<=1 for exactly one cycle; go to IDLE.
- Latency: VALID_OUT rises NUM_INPUTS+1 cycles after VALID_IN is sampled.
- BUSY_OUT is high from edge k until VALID_OUT rises. VALID_OUT and BUSY_OUT are never high in the same cycle.
- PRODUCTS_OUT and SAT_OUT change only at the DONE edge; they hold their value until the next batch's DONE edge.
- No partial updates are ever visible on PRODUCTS_OUT.
- VALID_IN while BUSY_OUT is high: ignored, not queued.
- VALID_IN high in the VALID_OUT cycle (state IDLE): accepted.
  - Back-to-back throughput is one batch per NUM_INPUTS+2 cycles.
- Reset mid-batch: aborts immediately, with no VALID_OUT pulse. PRODUCTS_OUT returns to 0.
- Counter width is clog2(NUM_INPUTS).
- All registers are updated only by clock or reset; there is no combinational path from input to output.

Test Plan (WIDTH=8, FRAC_BITS=3, NUM_INPUTS=4; 1.0 = 8):
- Nominal:
  - Stimulus: values {16,-12,-1,8}, weights {12,20,1,8}, VALID_IN pulse.
  - Required: VALID_OUT 5 cycles later; PRODUCTS_OUT {24,-30,-1,8} (3.0, -3.75, -0.125 floor, 1.0); SAT_OUT=0; BUSY_OUT high for the 5 cycles before.
- Saturation:
  - Stimulus: values {64,-128,-128,0}, weights {32,16,-128,5}.
  - Required: PRODUCTS_OUT {127,-128,127,0}; SAT_OUT=1.
- Ignored request:
  - Stimulus: a second VALID_IN with different data 2 cycles after the first.
  - Required: exactly one VALID_OUT; data equals the first batch; the following batch is unaffected.
- Back-to-back:
  - Stimulus: VALID_IN asserted in the VALID_OUT cycle.
  - Required: the second VALID_OUT exactly 6 cycles after the first; PRODUCTS_OUT held stable between the two pulses.
- Reset mid-batch:
  - Stimulus: RSTN low asynchronously 2 cycles into MULTIPLY.
  - Required: all outputs 0 immediately, no VALID_OUT; a fresh batch after release yields correct products.
- Input hold:
  - Stimulus: change VALUES_IN/WEIGHTS_IN every cycle after acceptance.
  - Required: products reflect only the operands latched at acceptance.
